// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter for the single register-file access port.
// Requester A (I2C slave) has fixed priority; B (gain auto-tuner) is protected by a starvation guard.
module reg_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_write,
  input  logic       a_lock,
  input  logic [7:0] a_index,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_write,
  input  logic       b_lock,
  input  logic [7:0] b_index,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       reg_write,
  output logic       reg_read,
  output logic [7:0] reg_index,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       owner,
  output logic       lock_err
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] wdata_q, wdata_d;
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] lockcnt_q, lockcnt_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;

  logic grant_a, grant_b;
  logic owner_req, owner_lock;

  assign owner_req  = owner_q ? b_req  : a_req;
  assign owner_lock = owner_q ? b_lock : a_lock;

  // A held lock admits only its owner; otherwise A wins unless B has waited STARVE_LIMIT grants.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE) begin
      if (lock_q) begin
        grant_a = !owner_q && a_req;
        grant_b =  owner_q && b_req;
      end else if (a_req && b_req) begin
        if (starve_q == STARVE_MAX) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    lockcnt_d = lockcnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    lock_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          state_d   = S_ISSUE;
          owner_d   = grant_b;
          wr_d      = grant_b ? b_write : a_write;
          idx_d     = grant_b ? b_index : a_index;
          wdata_d   = grant_b ? b_wdata : a_wdata;
          lock_d    = grant_b ? b_lock  : a_lock;
          lockcnt_d = 8'd0;
          if (grant_a && b_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (lock_q) begin
          // An idle owner that has dropped its lock bit releases at once; otherwise the timeout runs.
          if (!owner_lock) begin
            lock_d    = 1'b0;
            lockcnt_d = 8'd0;
          end else if (!owner_req) begin
            if (lockcnt_q == LOCK_LAST) begin
              lock_d    = 1'b0;
              lockcnt_d = 8'd0;
              lock_err  = 1'b1;
            end else begin
              lockcnt_d = lockcnt_q + 8'd1;
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          if (owner_q) begin
            b_rdata_d = reg_rdata;
          end else begin
            a_rdata_d = reg_rdata;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      idx_q     <= 8'd0;
      wdata_q   <= 8'd0;
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
      starve_q  <= 4'd0;
      lockcnt_q <= 8'd0;
      a_rdata_q <= 8'd0;
      b_rdata_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      lockcnt_q <= lockcnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Strobes and acks decode the state register directly so reset removes them immediately.
  assign reg_write = (state_q == S_ISSUE) &&  wr_q;
  assign reg_read  = (state_q == S_ISSUE) && !wr_q;
  assign reg_index = idx_q;
  assign reg_wdata = wdata_q;
  assign a_ack     = (state_q == S_RESP) && !owner_q;
  assign b_ack     = (state_q == S_RESP) &&  owner_q;
  assign a_rdata   = (a_ack && !wr_q) ? reg_rdata : a_rdata_q;
  assign b_rdata   = (b_ack && !wr_q) ? reg_rdata : b_rdata_q;
  assign owner     = owner_q;

endmodule
